// File: rtl/operand_sequencer.sv
// rtl/operand_sequencer.sv - queues operand pairs and sequences them through a load/compute/capture datapath
// Optional OPSEQ_COUNT_EN adds a 16-bit pair_count of completed result handshakes.
module operand_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_a,
  input  logic [7:0]  s_b,
  output logic        dp_load,
  output logic        dp_compute,
  output logic [7:0]  dp_in_a,
  output logic [7:0]  dp_in_b,
  input  logic [7:0]  dp_result,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data
`ifdef OPSEQ_COUNT_EN
  ,
  output logic [15:0] pair_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, CAPTURE, OUT} state_t;

  state_t state, next_state;

  logic [7:0]    mem_a [FIFO_DEPTH];
  logic [7:0]    mem_b [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop, handshake;

  assign full      = (count == DEPTH_CNT);
  assign empty     = (count == '0);
  // s_ready is gated by rst directly so it reads 0 throughout reset
  assign s_ready   = !rst && !full;
  assign push      = s_valid && s_ready;
  assign pop       = (state == LOAD);
  assign handshake = (state == OUT) && m_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= s_a;
      mem_b[wr_ptr] <= s_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      m_data <= '0;
    end else begin
      state <= next_state;
      if (state == CAPTURE) m_data <= dp_result;
    end
  end

  always_comb begin
    next_state = state;
    dp_load    = 1'b0;
    dp_compute = 1'b0;
    dp_in_a    = '0;
    dp_in_b    = '0;
    m_valid    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) next_state = LOAD;
      end
      LOAD: begin
        dp_load    = 1'b1;
        dp_in_a    = mem_a[rd_ptr];
        dp_in_b    = mem_b[rd_ptr];
        next_state = COMPUTE;
      end
      COMPUTE: begin
        dp_compute = 1'b1;
        next_state = CAPTURE;
      end
      CAPTURE: begin
        next_state = OUT;
      end
      OUT: begin
        m_valid = 1'b1;
        if (m_ready) next_state = empty ? IDLE : LOAD;
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef OPSEQ_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            pair_count <= '0;
    else if (handshake) pair_count <= pair_count + 16'd1;
  end
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_operand_sequencer.sv
// tb/tb_operand_sequencer.sv - directed self-checking bench for operand_sequencer with an adder datapath stage
module tb_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid, s_ready;
  logic [7:0] s_a, s_b;
  logic       dp_load, dp_compute;
  logic [7:0] dp_in_a, dp_in_b, dp_result;
  logic       m_valid, m_ready;
  logic [7:0] m_data;
`ifdef OPSEQ_COUNT_EN
  logic [15:0] pair_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] va [16];
  logic [7:0] vb [16];
  logic [7:0] ra, rb;

  always #5 clk = ~clk;

  operand_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .dp_load(dp_load), .dp_compute(dp_compute),
    .dp_in_a(dp_in_a), .dp_in_b(dp_in_b), .dp_result(dp_result),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
`ifdef OPSEQ_COUNT_EN
    , .pair_count(pair_count)
`endif
  );

  // Datapath stage: latch operands on load, registered sum on compute
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra <= '0; rb <= '0; dp_result <= '0;
    end else begin
      if (dp_load) begin ra <= dp_in_a; rb <= dp_in_b; end
      if (dp_compute) dp_result <= ra + rb;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, m_valid}, 32'd1);
  endtask

  // Hold s_valid high for a number of cycles, presenting va/vb[start+accepted]
  task automatic fill(input int start, input int cycles, output int acc);
    logic rdy;
    acc = 0;
    s_valid = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      s_a = va[start+acc];
      s_b = vb[start+acc];
      rdy = s_ready;
      @(negedge clk);
      if (rdy) acc++;
    end
    s_valid = 1'b0;
  endtask

  task automatic drain(input int first, input int n);
    m_ready = 1'b1;
    for (int k = first; k < first + n; k++) begin
      wait_valid($sformatf("drain_valid_%0d", k));
      chk($sformatf("drain_data_%0d", k), {24'd0, m_data}, {24'd0, va[k] + vb[k]});
      @(negedge clk);
    end
  endtask

  initial begin
    int acc;
    int bad;
    va[0] = 8'h11; vb[0] = 8'h01;
    va[1] = 8'h22; vb[1] = 8'h02;
    va[2] = 8'h33; vb[2] = 8'h03;
    va[3] = 8'h80; vb[3] = 8'h90;
    va[4] = 8'hFF; vb[4] = 8'hFF;
    va[5] = 8'h05; vb[5] = 8'h06;
    va[6] = 8'h07; vb[6] = 8'h08;
    va[7] = 8'h09; vb[7] = 8'h0A;
    for (int i = 8; i < 16; i++) begin va[i] = 8'(i); vb[i] = 8'(2*i); end

    rst = 1'b1; s_valid = 1'b0; s_a = '0; s_b = '0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data", {24'd0, m_data}, 32'd0);
    chk("rst_dp_strobes", {30'd0, dp_load, dp_compute}, 32'd0);
    chk("rst_dp_in", {16'd0, dp_in_a, dp_in_b}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_s_ready", {31'd0, s_ready}, 32'd1);
    @(negedge clk);

    // Latency for one pair into an idle sequencer
    m_ready = 1'b1; s_valid = 1'b1; s_a = 8'h12; s_b = 8'h34;
    @(negedge clk);
    s_valid = 1'b0;
    chk("lat_n_load", {31'd0, dp_load}, 32'd0);
    @(negedge clk);
    chk("lat_n1_load", {31'd0, dp_load}, 32'd1);
    chk("lat_n1_in", {16'd0, dp_in_a, dp_in_b}, 32'h1234);
    chk("lat_n1_compute", {31'd0, dp_compute}, 32'd0);
    @(negedge clk);
    chk("lat_n2_compute", {31'd0, dp_compute}, 32'd1);
    chk("lat_n2_load", {31'd0, dp_load}, 32'd0);
    chk("lat_n2_in", {16'd0, dp_in_a, dp_in_b}, 32'd0);
    @(negedge clk);
    chk("lat_n3_valid", {31'd0, m_valid}, 32'd0);
    chk("lat_n3_compute", {31'd0, dp_compute}, 32'd0);
    @(negedge clk);
    chk("lat_n4_valid", {31'd0, m_valid}, 32'd1);
    chk("lat_n4_data", {24'd0, m_data}, 32'h46);
    @(negedge clk);
    chk("lat_after_hs", {31'd0, m_valid}, 32'd0);

    // 8-bit wrap passes through unmodified
    s_valid = 1'b1; s_a = 8'hF0; s_b = 8'h20;
    @(negedge clk);
    s_valid = 1'b0;
    wait_valid("wrap_valid");
    chk("wrap_data", {24'd0, m_data}, 32'h10);
    @(negedge clk);

    // Backpressure: 4 queued + 1 in flight, then full
    m_ready = 1'b0;
    fill(0, 12, acc);
    chk("bp_accepted", acc, 32'd5);
    chk("bp_s_ready", {31'd0, s_ready}, 32'd0);
    chk("bp_m_valid", {31'd0, m_valid}, 32'd1);
    chk("bp_data0", {24'd0, m_data}, 32'h12);
    repeat (3) @(negedge clk);
    chk("bp_hold", {24'd0, m_data}, 32'h12);
    drain(0, 5);
    chk("bp_drained", {31'd0, m_valid}, 32'd0);
    chk("bp_ready_back", {31'd0, s_ready}, 32'd1);

    // Push and pop together at occupancy 2
    m_ready = 1'b0;
    s_valid = 1'b1; s_a = va[8]; s_b = vb[8];
    @(negedge clk);
    s_a = va[9]; s_b = vb[9];
    @(negedge clk);
    chk("pp_load_cycle", {31'd0, dp_load}, 32'd1);
    chk("pp_ready_before", {31'd0, s_ready}, 32'd1);
    s_a = va[10]; s_b = vb[10];
    @(negedge clk);
    s_valid = 1'b0;
    chk("pp_ready_after", {31'd0, s_ready}, 32'd1);
    fill(11, 6, acc);
    chk("pp_room_left", acc, 32'd2);
    chk("pp_full", {31'd0, s_ready}, 32'd0);
    drain(8, 5);
`ifdef OPSEQ_COUNT_EN
    chk("cnt_value", {16'd0, pair_count}, 32'd12);
`endif

    // Reset during COMPUTE with two pairs queued
    m_ready = 1'b1;
    s_valid = 1'b1; s_a = va[5]; s_b = vb[5];
    @(negedge clk);
    s_a = va[6]; s_b = vb[6];
    @(negedge clk);
    s_a = va[7]; s_b = vb[7];
    @(negedge clk);
    s_valid = 1'b0;
    chk("mid_compute", {31'd0, dp_compute}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("mid_rst_outs", {29'd0, dp_load, dp_compute, m_valid}, 32'd0);
    chk("mid_rst_data", {8'd0, m_data, dp_in_a, dp_in_b}, 32'd0);
`ifdef OPSEQ_COUNT_EN
    chk("cnt_rst", {16'd0, pair_count}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rel_ready", {31'd0, s_ready}, 32'd1);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (m_valid || dp_load || dp_compute) bad++;
    end
    chk("mid_no_spurious", bad, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
